// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - condition-code register with shadow stack and branch-condition evaluation
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   valid_i, op_i         flag-update request and operation (ADD/SUB/LOGIC/LOAD)
//   a_i, b_i              execute-stage operands (b_i[3:0] carries {N,Z,C,V} for LOAD)
//   mask_i                per-flag write enable {N,Z,C,V}
//   push_i, pop_i         shadow-stack save / restore of the flags
//   cond_i, cond_true_o   branch condition code and its result on flags_o
//   flags_o               registered {N,Z,C,V}
//   depth_o               shadow-stack occupancy
//   ovf_o, unf_o          sticky push-while-full / pop-while-empty
//   err_o                 one-cycle pulse after a cycle with push_i and pop_i together
module flag_unit #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4,
  localparam int DW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       mask_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [3:0]       cond_i,
  output logic [3:0]       flags_o,
  output logic             cond_true_o,
  output logic [DW-1:0]    depth_o,
  output logic             ovf_o,
  output logic             unf_o,
  output logic             err_o
);

  localparam logic [1:0] OP_ADD   = 2'd0;
  localparam logic [1:0] OP_SUB   = 2'd1;
  localparam logic [1:0] OP_LOGIC = 2'd2;

  logic [3:0]    flags_q, flags_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          err_q, err_d;
  logic [3:0]    stack_q [STACK_DEPTH];

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic [3:0]       calc;
  logic [3:0]       top;
  logic             lone_push, lone_pop, full, empty, push_ok, pop_ok;

  // Flags the ALU operation would produce; LOGIC carries C/V through so the
  // mask cannot change them.
  always_comb begin
    sum = '0;
    case (op_i)
      OP_ADD:  sum = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  sum = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
      default: sum = '0;
    endcase
    res  = sum[WIDTH-1:0];
    calc = flags_q;
    case (op_i)
      OP_ADD: calc = {res[WIDTH-1], (res == '0), sum[WIDTH],
                      (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1])};
      OP_SUB: calc = {res[WIDTH-1], (res == '0), sum[WIDTH],
                      (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1])};
      OP_LOGIC: calc = {a_i[WIDTH-1], (a_i == '0), flags_q[1], flags_q[0]};
      default: calc = b_i[3:0];
    endcase
  end

  // Stack top lives at entry depth-1.
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) top = stack_q[i];
    end
  end

  // A simultaneous push and pop cancels both stack operations.
  assign lone_push = push_i && !pop_i;
  assign lone_pop  = pop_i && !push_i;
  assign full      = (depth_q == DW'(STACK_DEPTH));
  assign empty     = (depth_q == '0);
  assign push_ok   = lone_push && !full;
  assign pop_ok    = lone_pop && !empty;

  always_comb begin
    flags_d = flags_q;
    if (pop_ok) begin
      flags_d = top;
    end else if (valid_i) begin
      flags_d = (calc & mask_i) | (flags_q & ~mask_i);
    end
    depth_d = depth_q;
    if (push_ok) depth_d = depth_q + DW'(1);
    else if (pop_ok) depth_d = depth_q - DW'(1);
    ovf_d = ovf_q | (lone_push && full);
    unf_d = unf_q | (lone_pop && empty);
    err_d = push_i && pop_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      err_q   <= err_d;
    end
  end

  // Stack contents need no reset; a push always saves the pre-update flags.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (!rst && push_ok && depth_q == DW'(i)) stack_q[i] <= flags_q;
    end
  end

  always_comb begin
    cond_true_o = 1'b0;
    case (cond_i)
      4'd0:    cond_true_o = flags_q[2];
      4'd1:    cond_true_o = !flags_q[2];
      4'd2:    cond_true_o = flags_q[1];
      4'd3:    cond_true_o = !flags_q[1];
      4'd4:    cond_true_o = flags_q[3];
      4'd5:    cond_true_o = !flags_q[3];
      4'd6:    cond_true_o = flags_q[0];
      4'd7:    cond_true_o = !flags_q[0];
      4'd8:    cond_true_o = flags_q[1] && !flags_q[2];
      4'd9:    cond_true_o = !flags_q[1] || flags_q[2];
      4'd10:   cond_true_o = (flags_q[3] == flags_q[0]);
      4'd11:   cond_true_o = (flags_q[3] != flags_q[0]);
      4'd12:   cond_true_o = !flags_q[2] && (flags_q[3] == flags_q[0]);
      4'd13:   cond_true_o = flags_q[2] || (flags_q[3] != flags_q[0]);
      4'd14:   cond_true_o = 1'b1;
      default: cond_true_o = 1'b0;
    endcase
  end

  assign flags_o = flags_q;
  assign depth_o = depth_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_flag_unit.sv
// tb/tb_flag_unit.sv - self-checking bench for flag_unit
module tb_flag_unit;

  localparam int W  = 16;
  localparam int SD = 4;
  localparam int DW = $clog2(SD + 1);

  logic          clk = 1'b0;
  logic          rst, valid_i, push_i, pop_i;
  logic [1:0]    op_i;
  logic [W-1:0]  a_i, b_i;
  logic [3:0]    mask_i, cond_i;
  logic [3:0]    flags_o;
  logic          cond_true_o, ovf_o, unf_o, err_o;
  logic [DW-1:0] depth_o;

  int checks = 0;
  int errors = 0;

  flag_unit #(.WIDTH(W), .STACK_DEPTH(SD)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .mask_i(mask_i), .push_i(push_i), .pop_i(pop_i), .cond_i(cond_i),
    .flags_o(flags_o), .cond_true_o(cond_true_o), .depth_o(depth_o),
    .ovf_o(ovf_o), .unf_o(unf_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic rst, valid;
    logic [1:0] op;
    logic [15:0] a, b;
    logic [3:0] mask;
    logic push, pop;
    logic [3:0] cond;
    logic [3:0] ef;
    int ed;
    logic eo, eu, ee, ec;
  } vec_t;

  function automatic vec_t mk(bit r, bit v, bit [1:0] op, bit [15:0] a, bit [15:0] b,
                              bit [3:0] m, bit pu, bit po, bit [3:0] c, bit [3:0] ef,
                              int ed, bit eo, bit eu, bit ee, bit ec);
    vec_t x;
    x.rst = r; x.valid = v; x.op = op; x.a = a; x.b = b; x.mask = m;
    x.push = pu; x.pop = po; x.cond = c; x.ef = ef; x.ed = ed;
    x.eo = eo; x.eu = eu; x.ee = ee; x.ec = ec;
    return x;
  endfunction

  // Behavioural reference: integer arithmetic and a queue for the stack.
  logic [3:0] m_flags;
  logic [3:0] m_stk[$];
  bit         m_ovf, m_unf, m_err;

  function automatic longint sval(logic [W-1:0] x);
    return x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
  endfunction

  function automatic bit ovr(longint s);
    return (s > (longint'(1) << (W-1)) - 1) || (s < -(longint'(1) << (W-1)));
  endfunction

  function automatic bit cond_eval(logic [3:0] f, logic [3:0] c);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      0: return z;          1: return !z;
      2: return cy;         3: return !cy;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return cy && !z;   9: return !cy || z;
      10: return n == v;    11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    logic [3:0] nf, u;
    longint ua, ub, r;
    if (rst) begin
      m_flags = 0; m_ovf = 0; m_unf = 0; m_err = 0; m_stk.delete();
      return;
    end
    m_err = push_i && pop_i;
    nf = m_flags;
    ua = longint'(a_i); ub = longint'(b_i);
    if (valid_i) begin
      u = m_flags;
      case (op_i)
        0: begin
          r = (ua + ub) % (longint'(1) << W);
          u = {r >= (longint'(1) << (W-1)), r == 0, (ua + ub) >= (longint'(1) << W),
               ovr(sval(a_i) + sval(b_i))};
        end
        1: begin
          r = (ua - ub + (longint'(1) << W)) % (longint'(1) << W);
          u = {r >= (longint'(1) << (W-1)), r == 0, ua >= ub, ovr(sval(a_i) - sval(b_i))};
        end
        2: u = {sval(a_i) < 0, ua == 0, m_flags[1], m_flags[0]};
        default: u = b_i[3:0];
      endcase
      for (int k = 0; k < 4; k++) if (mask_i[k]) nf[k] = u[k];
    end
    if (push_i && !pop_i) begin
      if (m_stk.size() < SD) m_stk.push_back(m_flags);
      else m_ovf = 1;
    end
    if (pop_i && !push_i) begin
      if (m_stk.size() > 0) nf = m_stk.pop_back();
      else m_unf = 1;
    end
    m_flags = nf;
  endtask

  task automatic idle();
    rst = 0; valid_i = 0; op_i = 0; a_i = 0; b_i = 0; mask_i = 0; push_i = 0; pop_i = 0;
  endtask

  vec_t tbl[27];
  bit [W-1:0] corner[5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

  initial begin
    tbl[0]  = mk(1,0,0,16'h0,16'h0,4'h0,0,0,14, 4'h0,0,0,0,0,1);
    tbl[1]  = mk(0,1,0,16'h7FFF,16'h1,4'hF,0,0,10, 4'h9,0,0,0,0,1);
    tbl[2]  = mk(0,0,0,16'h0,16'h0,4'h0,0,0,11, 4'h9,0,0,0,0,0);
    tbl[3]  = mk(0,1,1,16'h5,16'h5,4'hF,0,0,0, 4'h6,0,0,0,0,1);
    tbl[4]  = mk(0,0,0,16'h0,16'h0,4'h0,0,0,8, 4'h6,0,0,0,0,0);
    tbl[5]  = mk(0,1,1,16'h0,16'h1,4'hF,0,0,3, 4'h8,0,0,0,0,1);
    tbl[6]  = mk(0,1,3,16'h0,16'hF,4'hF,0,0,15, 4'hF,0,0,0,0,0);
    tbl[7]  = mk(0,1,2,16'h8000,16'h0,4'hF,0,0,4, 4'hB,0,0,0,0,1);
    tbl[8]  = mk(0,1,0,16'hFFFF,16'h1,4'h4,0,0,1, 4'hF,0,0,0,0,0);
    tbl[9]  = mk(0,1,3,16'h0,16'h1,4'hF,0,0,6, 4'h1,0,0,0,0,1);
    tbl[10] = mk(0,1,3,16'h0,16'h2,4'hF,1,0,2, 4'h2,1,0,0,0,1);
    tbl[11] = mk(0,1,3,16'h0,16'h3,4'hF,1,0,9, 4'h3,2,0,0,0,0);
    tbl[12] = mk(0,1,3,16'h0,16'h4,4'hF,1,0,0, 4'h4,3,0,0,0,1);
    tbl[13] = mk(0,0,0,16'h0,16'h0,4'h0,1,0,12, 4'h4,4,0,0,0,0);
    tbl[14] = mk(0,0,0,16'h0,16'h0,4'h0,1,0,13, 4'h4,4,1,0,0,1);
    tbl[15] = mk(0,0,0,16'h0,16'h0,4'h0,0,1,7, 4'h4,3,1,0,0,1);
    tbl[16] = mk(0,0,0,16'h0,16'h0,4'h0,0,1,11, 4'h3,2,1,0,0,1);
    tbl[17] = mk(0,0,0,16'h0,16'h0,4'h0,0,1,5, 4'h2,1,1,0,0,1);
    tbl[18] = mk(0,0,0,16'h0,16'h0,4'h0,0,1,10, 4'h1,0,1,0,0,0);
    tbl[19] = mk(0,0,0,16'h0,16'h0,4'h0,0,1,14, 4'h1,0,1,1,0,1);
    tbl[20] = mk(0,0,0,16'h0,16'h0,4'h0,1,1,15, 4'h1,0,1,1,1,0);
    tbl[21] = mk(0,0,0,16'h0,16'h0,4'h0,0,0,7, 4'h1,0,1,1,0,0);
    tbl[22] = mk(0,1,3,16'h0,16'h9,4'hF,1,0,4, 4'h9,1,1,1,0,1);
    tbl[23] = mk(0,1,3,16'h0,16'h6,4'hF,0,1,4, 4'h1,0,1,1,0,0);
    tbl[24] = mk(0,0,0,16'h0,16'h0,4'h0,1,0,6, 4'h1,1,1,1,0,1);
    tbl[25] = mk(0,0,0,16'h0,16'h0,4'h0,1,0,14, 4'h1,2,1,1,0,1);
    tbl[26] = mk(1,1,0,16'h7FFF,16'h1,4'hF,1,0,0, 4'h0,0,0,0,0,0);

    idle(); rst = 1; cond_i = 0;

    for (int i = 0; i < 27; i++) begin
      rst = tbl[i].rst; valid_i = tbl[i].valid; op_i = tbl[i].op;
      a_i = tbl[i].a; b_i = tbl[i].b; mask_i = tbl[i].mask;
      push_i = tbl[i].push; pop_i = tbl[i].pop; cond_i = tbl[i].cond;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d flags", i), 32'(flags_o), 32'(tbl[i].ef));
      chk($sformatf("tbl%0d depth", i), 32'(depth_o), 32'(tbl[i].ed));
      chk($sformatf("tbl%0d ovf", i), 32'(ovf_o), 32'(tbl[i].eo));
      chk($sformatf("tbl%0d unf", i), 32'(unf_o), 32'(tbl[i].eu));
      chk($sformatf("tbl%0d err", i), 32'(err_o), 32'(tbl[i].ee));
      chk($sformatf("tbl%0d cond", i), 32'(cond_true_o), 32'(tbl[i].ec));
    end

    // No same-cycle forwarding: the branch sees the old flags until the edge.
    idle(); valid_i = 1; op_i = 0; a_i = 16'h7FFF; b_i = 16'h0001; mask_i = 4'hF; cond_i = 6;
    #1;
    chk("nofwd flags", 32'(flags_o), 32'h0);
    chk("nofwd cond", 32'(cond_true_o), 32'h0);
    @(posedge clk); #1;
    chk("fwd flags", 32'(flags_o), 32'h9);
    chk("fwd cond", 32'(cond_true_o), 32'h1);

    // Every condition code against every flag pattern.
    for (int f = 0; f < 16; f++) begin
      idle(); valid_i = 1; op_i = 3; b_i = W'(f); mask_i = 4'hF;
      @(posedge clk); #1;
      idle();
      chk($sformatf("load%0d", f), 32'(flags_o), 32'(f));
      for (int c = 0; c < 16; c++) begin
        cond_i = 4'(c);
        #1;
        chk($sformatf("cond f=%0h c=%0d", f, c), 32'(cond_true_o), 32'(cond_eval(4'(f), 4'(c))));
      end
    end

    // Randomised run against the reference model.
    idle(); rst = 1;
    @(posedge clk); #1;
    model_step();
    for (int n = 0; n < 800; n++) begin
      rst     = ($urandom_range(0, 49) == 0);
      valid_i = ($urandom_range(0, 9) < 6);
      op_i    = 2'($urandom_range(0, 3));
      a_i     = ($urandom_range(0, 1) != 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      b_i     = ($urandom_range(0, 1) != 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      mask_i  = 4'($urandom);
      push_i  = ($urandom_range(0, 3) == 0);
      pop_i   = ($urandom_range(0, 3) == 0);
      cond_i  = 4'($urandom);
      if (pop_i && !push_i && m_stk.size() == 0) valid_i = 0;
      @(posedge clk); #1;
      model_step();
      chk("rnd flags", 32'(flags_o), 32'(m_flags));
      chk("rnd depth", 32'(depth_o), 32'(m_stk.size()));
      chk("rnd ovf", 32'(ovf_o), 32'(m_ovf));
      chk("rnd unf", 32'(unf_o), 32'(m_unf));
      chk("rnd err", 32'(err_o), 32'(m_err));
      chk("rnd cond", 32'(cond_true_o), 32'(cond_eval(m_flags, cond_i)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
# flag_unit

Parametrised condition-code unit for the pipelined processor. It computes N/Z/C/V from execute-stage operands and holds them in a flag register with per-flag write enables. It adds a LIFO shadow stack for interrupt save/restore, and evaluates a 4-bit branch condition against the registered flags. It sits after the ALU in the execute stage and feeds branch resolution.

## Interface
- WIDTH, 16: operand width in bits (≥2).
- STACK_DEPTH, 4: shadow-stack entries (≥1); DW = $clog2(STACK_DEPTH+1).
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  flag-update request this cycle.
- op_i  in  2  0=ADD, 1=SUB, 2=LOGIC, 3=LOAD.
- a_i  in  WIDTH  operand A; for LOGIC, the ALU result.
- b_i  in  WIDTH  operand B; for LOAD, b_i[3:0] = {N,Z,C,V}.
- mask_i  in  4  per-flag update enable {N,Z,C,V}.
- push_i  in  1  save current flags to the stack.
- pop_i  in  1  restore flags from the stack top.
- cond_i  in  4  branch condition code.
- flags_o  out  4  registered {N,Z,C,V}.
- cond_true_o  out  1  cond_i evaluated on flags_o (combinational).
- depth_o  out  DW  current stack occupancy.
- ovf_o  out  1  sticky: push attempted while full.
- unf_o  out  1  sticky: pop attempted while empty.
- err_o  out  1  one-cycle pulse: push and pop in the same cycle.

## Operation
- Internal sum s is WIDTH+1 bits; r = s[WIDTH-1:0]; msb means bit WIDTH-1.
- ADD: s = {0,a} + {0,b}.
  - N = r msb; Z = (r == 0); C = s[WIDTH].
  - V = (a msb == b msb) && (r msb != a msb).
- SUB: s = {0,a} + {0,~b} + 1.
  - N, Z as for ADD; C = s[WIDTH], where 1 means no borrow.
  - V = (a msb != b msb) && (r msb != a msb).
- LOGIC: N = a msb; Z = (a == 0); C and V hold their old values regardless of mask_i.
- LOAD: flags take b_i[3:0] directly.
- Only flag bits with mask_i set are written; unmasked bits hold.
- Stack is STACK_DEPTH × 4-bit LIFO.
  - Push writes the pre-update flags_o to entry depth_o, then depth_o is incremented.
  - Pop loads entry depth_o-1 into all four flags (mask ignored), then depth_o is decremented.
- Priority within a cycle, highest first:
  1. push_i && pop_i: neither is performed; err_o=1. A valid_i update in the same cycle still applies.
  2. pop_i (non-empty): the pop is performed and any valid_i update is discarded.
  3. valid_i: normal flag update. A lone push_i in the same cycle still saves the pre-update flags.
- Full push: no write, depth_o unchanged, ovf_o set. Empty pop: flags unchanged, unf_o set. Both stay set until rst.
- cond_i encodings:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C.
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V.
  - 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.

## Timing
- Reset values: flags_o=0, depth_o=0, ovf_o=0, unf_o=0, err_o=0. Stack contents are don't-care.
- rst overrides every request in the same cycle and may be asserted mid-operation.
- An update, push or pop presented in cycle t is visible on flags_o/depth_o at t+1 (latency 1).
- Back-to-back requests are accepted every cycle; there is no stall or backpressure.
- cond_true_o follows flags_o and cond_i combinationally. A branch in cycle t+1 sees the flags written in cycle t; there is no same-cycle forwarding.
- Pop at depth 1 leaves depth_o=0; push at depth STACK_DEPTH-1 makes depth_o=STACK_DEPTH (full).

## Test plan
- ADD a=0x7FFF, b=0x0001, mask=F → next cycle flags_o=1001 (N=1,Z=0,C=0,V=1); cond 10 (GE) true, 11 (LT) false.
- SUB a=0x0005, b=0x0005, mask=F → flags_o=0110; EQ true, HI false.
  - Then SUB a=0x0000, b=0x0001 → flags_o=1000 (borrow, C=0).
- LOAD b=0x000F, then LOGIC a=0x8000 with mask=F → flags_o=1011 (C,V held).
  - Then ADD a=0xFFFF, b=0x0001 with mask=0100 → only Z updates: flags_o=1111.
- Depth 4, four pushes of distinct LOAD values, then a fifth push → depth_o=4 and ovf_o=1.
  - Then four pops → flags_o returns the values in reverse order and depth_o ends at 0.
- pop at depth 0 → unf_o=1, flags unchanged.
  - push+pop in the same cycle → err_o pulse, depth unchanged.
  - pop with valid_i at depth 1 → the popped value wins.
- rst asserted at depth 2 during an ADD → next cycle all outputs at their reset values, sticky flags cleared.
